// File: rtl/ascii_num_parser_if.sv
// Character-in / result-out bundle for the ASCII number parser.
// master: character source and result consumer side; slave: the parser.
// Handshakes are valid/ready on both the character and the result channel.
interface ascii_num_parser_if #(
    parameter int WIDTH = 32
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_value;
    logic             out_hex;
    logic             out_error;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_value, out_hex, out_error, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_value, out_hex, out_error, out_valid
    );
endinterface

// File: rtl/ascii_num_parser.sv
// Purpose: parse whitespace-terminated ASCII decimal (optional '-') or 'h'-prefixed hex tokens into WIDTH-bit values.
// Latency: result valid the cycle after the terminating whitespace is accepted; one dead input cycle per token.
// Backpressure: in_ready drops while a result is pending; result is held until out_ready. Macro ASCII_NUM_UNDERSCORE_EN enables '_' separators.
module ascii_num_parser #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    ascii_num_parser_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DEC  = 3'd1,
        HEX  = 3'd2,
        SKIP = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam logic [WIDTH+3:0] TEN     = (WIDTH+4)'(10);
    localparam logic [WIDTH-1:0] NEG_LIM = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             neg_q, neg_d;
    logic             hex_q, hex_d;
    logic             err_q, err_d;
    logic [7:0]       ndig_q, ndig_d;

    logic [7:0]       c;
    logic             is_ws, is_dec, is_alpha, is_minus, is_h, is_us;
    logic [3:0]       nib;
    logic [WIDTH+3:0] dec_wide, hex_wide;
    logic             dec_ovf, hex_ovf;
    logic             in_rdy, in_fire;
    logic [7:0]       ndig_inc;
    logic             term_err;

    assign c        = bus.in_data;
    assign in_rdy   = rst_n && (state_q != OUT);
    assign in_fire  = bus.in_valid && in_rdy;
    assign ndig_inc = (ndig_q == 8'hFF) ? ndig_q : ndig_q + 8'd1;
    // A terminator closes the token; an empty digit field or a too-large negative magnitude is an error.
    assign term_err = (ndig_q == 8'd0) || (neg_q && (acc_q > NEG_LIM));

    // Character classification and next-accumulator candidates with overflow detection.
    always_comb begin
        is_ws    = (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
        is_dec   = (c >= 8'h30) && (c <= 8'h39);
        is_alpha = ((c >= 8'h61) && (c <= 8'h66)) || ((c >= 8'h41) && (c <= 8'h46));
        is_minus = (c == 8'h2D);
        is_h     = (c == 8'h68) || (c == 8'h48);
        is_us    = (c == 8'h5F);
        nib      = 4'h0;
        if (is_dec) begin
            nib = c[3:0];
        end else if (is_alpha) begin
            nib = c[3:0] + 4'd9;
        end
        // Exact value of acc*10+d and acc*16+d; any bit above WIDTH means overflow.
        dec_wide = ({4'b0000, acc_q} * TEN) + {{WIDTH{1'b0}}, nib};
        hex_wide = {acc_q, nib};
        dec_ovf  = |dec_wide[WIDTH+3:WIDTH];
        hex_ovf  = |hex_wide[WIDTH+3:WIDTH];
    end

    // Next-state and token accumulation.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        hex_d   = hex_q;
        err_d   = err_q;
        ndig_d  = ndig_q;
        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    if (is_ws) begin
                        state_d = IDLE;
                    end else if (is_dec) begin
                        // acc is zero here, so dec_wide is just the digit.
                        acc_d  = dec_wide[WIDTH-1:0];
                        ndig_d = 8'd1;
                        if (dec_ovf) begin
                            err_d   = 1'b1;
                            state_d = SKIP;
                        end else begin
                            state_d = DEC;
                        end
                    end else if (is_minus) begin
                        neg_d   = 1'b1;
                        ndig_d  = 8'd0;
                        state_d = DEC;
                    end else if (is_h) begin
                        hex_d   = 1'b1;
                        ndig_d  = 8'd0;
                        state_d = HEX;
                    end else begin
                        err_d   = 1'b1;
                        state_d = SKIP;
                    end
                end
            end
            DEC: begin
                if (in_fire) begin
                    if (is_dec) begin
                        if (dec_ovf) begin
                            err_d   = 1'b1;
                            state_d = SKIP;
                        end else begin
                            acc_d  = dec_wide[WIDTH-1:0];
                            ndig_d = ndig_inc;
                        end
                    end else if (is_ws) begin
                        err_d   = err_q || term_err;
                        state_d = OUT;
                    end
`ifdef ASCII_NUM_UNDERSCORE_EN
                    else if (is_us && (ndig_q != 8'd0)) begin
                        state_d = DEC;
                    end
`endif
                    else begin
                        err_d   = 1'b1;
                        state_d = SKIP;
                    end
                end
            end
            HEX: begin
                if (in_fire) begin
                    if (is_dec || is_alpha) begin
                        if (hex_ovf) begin
                            err_d   = 1'b1;
                            state_d = SKIP;
                        end else begin
                            acc_d  = hex_wide[WIDTH-1:0];
                            ndig_d = ndig_inc;
                        end
                    end else if (is_ws) begin
                        err_d   = err_q || term_err;
                        state_d = OUT;
                    end
`ifdef ASCII_NUM_UNDERSCORE_EN
                    else if (is_us && (ndig_q != 8'd0)) begin
                        state_d = HEX;
                    end
`endif
                    else begin
                        err_d   = 1'b1;
                        state_d = SKIP;
                    end
                end
            end
            SKIP: begin
                if (in_fire && is_ws) begin
                    err_d   = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    neg_d   = 1'b0;
                    hex_d   = 1'b0;
                    err_d   = 1'b0;
                    ndig_d  = 8'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and token registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            hex_q   <= 1'b0;
            err_q   <= 1'b0;
            ndig_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            hex_q   <= hex_d;
            err_q   <= err_d;
            ndig_q  <= ndig_d;
        end
    end

    // Result fields are derived from held registers, so they stay stable through OUT.
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_hex   = (state_q == OUT) && hex_q;
    assign bus.out_error = (state_q == OUT) && err_q;
    assign bus.out_value = ((state_q == OUT) && !err_q) ? (neg_q ? (~acc_q + ONE) : acc_q) : '0;

endmodule

// File: tb/tb_ascii_num_parser.sv
// Directed bench for ascii_num_parser: token-level reference model, per-cycle output monitor,
// plus hand-computed literal checks on the model and on the observed result sequence.
module tb_ascii_num_parser;

    localparam int W = 32;
`ifdef ASCII_NUM_UNDERSCORE_EN
    localparam bit US_EN = 1'b1;
`else
    localparam bit US_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] v;
        bit          h;
        bit          e;
    } exp_t;

    logic clk;
    logic rst_n;
    ascii_num_parser_if #(.WIDTH(W)) bus ();

    ascii_num_parser #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  tokq[$];
    exp_t        expq[$];
    exp_t        obs[$];
    bit          lat_pending = 0;
    bit          done = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    function automatic bit is_ws(input logic [7:0] ch);
        return (ch == 8'h20) || (ch == 8'h09) || (ch == 8'h0A) || (ch == 8'h0D);
    endfunction

    // Reference: value of one complete token, from the textual rules.
    function automatic exp_t eval_tok(input logic [7:0] t[$]);
        exp_t         r;
        logic [127:0] mag, b128, d128;
        int           i, nd, d;
        bit           neg;
        logic [7:0]   ch;
        logic [31:0]  m32;
        r.v = 32'h0; r.h = 1'b0; r.e = 1'b0;
        mag = 128'h0; b128 = 128'd10; i = 0; nd = 0; neg = 1'b0;
        if (t[0] == 8'h68 || t[0] == 8'h48) begin
            r.h = 1'b1; b128 = 128'd16; i = 1;
        end else if (t[0] == 8'h2D) begin
            neg = 1'b1; i = 1;
        end
        for (; i < t.size(); i++) begin
            ch = t[i];
            d  = -1;
            if (ch >= 8'h30 && ch <= 8'h39) d = int'(ch) - 48;
            else if (b128 == 128'd16 && ch >= 8'h61 && ch <= 8'h66) d = int'(ch) - 87;
            else if (b128 == 128'd16 && ch >= 8'h41 && ch <= 8'h46) d = int'(ch) - 55;
            if (US_EN && ch == 8'h5F && nd > 0) continue;
            if (d < 0) begin
                r.e = 1'b1;
                break;
            end
            d128 = 128'(d);
            mag  = mag * b128 + d128;
            nd++;
            if (mag > 128'hFFFF_FFFF) begin
                r.e = 1'b1;
                break;
            end
        end
        if (nd == 0) r.e = 1'b1;
        if (neg && mag > 128'h8000_0000) r.e = 1'b1;
        m32 = mag[31:0];
        if (!r.e) r.v = neg ? (32'h0 - m32) : m32;
        return r;
    endfunction

    function automatic exp_t eval_str(input string s);
        logic [7:0] q[$];
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return eval_tok(q);
    endfunction

    // Per-cycle monitor: feeds accepted characters into the model and checks every result cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            tokq.delete();
            expq.delete();
            lat_pending = 1'b0;
        end else begin
            if (lat_pending) begin
                chk1("latency_out_valid", bus.out_valid, 1'b1);
                lat_pending = 1'b0;
            end
            chk1("in_ready_vs_out_valid", bus.in_ready, !bus.out_valid);
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    chk1("unexpected_result", bus.out_valid, 1'b0);
                end else begin
                    chk("out_value", bus.out_value, expq[0].v);
                    chk1("out_hex", bus.out_hex, expq[0].h);
                    chk1("out_error", bus.out_error, expq[0].e);
                    if (bus.out_ready) begin
                        obs.push_back('{v: bus.out_value, h: bus.out_hex, e: bus.out_error});
                        void'(expq.pop_front());
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                if (is_ws(bus.in_data)) begin
                    if (tokq.size() > 0) begin
                        expq.push_back(eval_tok(tokq));
                        lat_pending = 1'b1;
                    end
                    tokq.delete();
                end else begin
                    tokq.push_back(bus.in_data);
                end
            end
        end
    end

    task automatic send_char(input logic [7:0] ch);
        int n;
        bus.in_data  = ch;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk1("in_ready_timeout", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) chk1(name, bus.out_valid, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    exp_t m;

    initial begin
        rst_n         = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // Model pinned against hand-computed values.
        m = eval_str("123");
        chk("model_123", m.v, 32'd123);
        chk1("model_123_err", m.e, 1'b0);
        m = eval_str("-2147483649");
        chk1("model_neg_ovf_err", m.e, 1'b1);
        m = eval_str("hdeadBEEF");
        chk("model_hex_val", m.v, 32'hDEADBEEF);
        chk1("model_hex_flag", m.h, 1'b1);
        m = eval_str("4294967296");
        chk1("model_dec_ovf", m.e, 1'b1);
        m = eval_str("-0");
        chk("model_neg0", m.v, 32'h0);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_value", bus.out_value, 32'h0);
        chk1("rst_out_error", bus.out_error, 1'b0);
        chk1("rst_out_hex", bus.out_hex, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk1("post_rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Decimal, negative, hex, overflow and malformed tokens.
        send_str("123 ");
        send_str("-2\n");
        send_str("-2147483648 ");
        send_str("-2147483649 ");
        send_str("h1234 ");
        send_str("HdeadBEEF ");
        send_str("h123456789 ");
        send_str("4294967295 ");
        send_str("4294967296 ");
        send_str("12x4 5 ");
        send_str("- ");
        send_str("h\t");
        send_str("-0 ");
        send_str("  \t7\r\n");
        send_str("+3 ");
        idle(3);

        // Backpressure: result 7 held with in_ready low, then 8 follows.
        bus.out_ready = 1'b0;
        fork
            send_str("7 8 ");
            begin
                wait_out_valid("bp_first_valid");
                repeat (5) begin
                    chk1("bp_in_ready_low", bus.in_ready, 1'b0);
                    chk("bp_held_value", bus.out_value, 32'd7);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        idle(3);

        // Reset mid-token discards the partial token.
        send_str("99");
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_str("5 ");
        idle(3);

        // Reset while a result is pending drops it.
        bus.out_ready = 1'b0;
        send_str("3 ");
        @(negedge clk);
        wait_out_valid("rst_out_valid_wait");
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send_str("4 ");
        send_str("1_000 ");
        send_str("_5 ");
        idle(3);

        // Irregular consumer readiness.
        fork
            begin
                send_str("hff 0 -1 65535 h0_f ");
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        idle(20);

        chk("drain_pending", 32'(expq.size()), 32'd0);

        // Hand-computed expectations on the observed result order.
        chk("obs_count", 32'(obs.size()), 32'd27);
        if (obs.size() >= 22) begin
            chk("obs0_123", obs[0].v, 32'd123);
            chk("obs1_neg2", obs[1].v, 32'hFFFFFFFE);
            chk("obs2_minint", obs[2].v, 32'h80000000);
            chk1("obs2_err", obs[2].e, 1'b0);
            chk1("obs3_err", obs[3].e, 1'b1);
            chk("obs3_val", obs[3].v, 32'h0);
            chk("obs4_hex", obs[4].v, 32'h00001234);
            chk("obs5_hex", obs[5].v, 32'hDEADBEEF);
            chk1("obs6_err", obs[6].e, 1'b1);
            chk1("obs6_hex", obs[6].h, 1'b1);
            chk("obs7_max", obs[7].v, 32'hFFFFFFFF);
            chk1("obs8_err", obs[8].e, 1'b1);
            chk1("obs9_err", obs[9].e, 1'b1);
            chk("obs10_5", obs[10].v, 32'd5);
            chk1("obs11_err", obs[11].e, 1'b1);
            chk1("obs13_err", obs[13].e, 1'b0);
            chk("obs16_7", obs[16].v, 32'd7);
            chk("obs17_8", obs[17].v, 32'd8);
            chk("obs18_5", obs[18].v, 32'd5);
            chk("obs19_4", obs[19].v, 32'd4);
            chk1("obs20_err", obs[20].e, !US_EN);
            chk("obs20_val", obs[20].v, US_EN ? 32'd1000 : 32'd0);
            chk1("obs21_err", obs[21].e, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ascii_num_parser.md
Name: ascii_num_parser

Overview:
- Receive side of the team's number-formatting path: parses a stream of ASCII characters back into binary integers.
- The formatting side renders values as decimal (%d, signed) and hex (%h) text; this block consumes that text one byte per handshake.
- Emits one WIDTH-bit result per whitespace-terminated token.
- Sits between a character source (UART RX, console FIFO) and register or memory write logic.

Parameters:
WIDTH, 32, result width in bits (2..64)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on clk rising edge
in_data  input  8  ASCII character
in_valid  input  1  in_data valid
in_ready  output  1  parser accepts in_data this cycle
out_value  output  WIDTH  parsed value (two's complement for negative decimal)
out_hex  output  1  token was hex
out_error  output  1  token malformed or overflowed; out_value = 0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous, active-low.
- Reset (rst_n=0 at edge):
  - state=IDLE; accumulator, neg, hex, error and digit-count cleared.
  - out_value=0, out_valid=0, out_error=0, out_hex=0, in_ready=0 during reset, in_ready=1 the cycle after.
  - Reset mid-token discards the partial token; reset during OUT drops the pending result.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- in_ready=1 in every state except OUT.
- Whitespace = 0x20, 0x09, 0x0A, 0x0D.
- States: IDLE, DEC, HEX, SKIP, OUT.
- IDLE:
  - whitespace: stay.
  - '0'-'9': acc=digit, ndig=1 -> DEC.
  - '-': neg=1, ndig=0 -> DEC.
  - 'h'/'H': hex=1, ndig=0 -> HEX.
  - anything else: error=1 -> SKIP.
- DEC:
  - digit: acc=acc*10+d, ndig++. If the exact result exceeds 2^WIDTH-1 (computed at WIDTH+4 bits), set error and go to SKIP.
  - whitespace: -> OUT.
  - other: error -> SKIP.
- HEX:
  - 0-9, a-f, A-F: acc=(acc<<4)|nibble, ndig++. If acc[WIDTH-1:WIDTH-4] was nonzero before the shift, set error and go to SKIP.
  - whitespace: -> OUT.
  - other: error -> SKIP.
- SKIP: consume until whitespace, then -> OUT with error=1.
- Terminator with ndig==0 ("-" or "h" alone): error=1.
- Negative decimal:
  - out_value = (~acc+1) truncated to WIDTH.
  - Magnitude above 2^(WIDTH-1) is an error.
  - "-0" yields 0 with no error.
- OUT:
  - out_valid=1; out_value, out_hex and out_error are held stable until handshake.
  - On error: out_value=0; out_hex reflects the 'h' prefix if one was seen.
  - On handshake: clear acc/neg/hex/error/ndig and go to IDLE; out_valid=0 the next cycle.
- Latency: terminator accepted at edge N -> out_valid=1 after edge N. Back-to-back tokens lose one cycle per token (in_ready=0 during OUT).
- No end-of-input flush: a token without a trailing terminator stays pending.

Optional Feature:
Macro ASCII_NUM_UNDERSCORE_EN.
- Defined: '_' (0x5F) is a digit separator in DEC and HEX when ndig>=1; it is ignored and does not change ndig. '_' in IDLE or directly after '-'/'h' is an error. Example: "h12_34 " -> 0x1234.
- Undefined: '_' is an ordinary illegal character -> SKIP, error.

Test Plan:
1. "123 " with out_ready=1 -> out_value=123, out_hex=0, out_error=0; out_valid high one cycle after the space is accepted.
2. "-2\n" -> out_value=0xFFFFFFFE. "-2147483648 " -> 0x80000000, no error. "-2147483649 " -> out_error=1, out_value=0.
3. "h1234 " then "HdeadBEEF " -> 0x00001234 (out_hex=1), then 0xDEADBEEF (out_hex=1). "h123456789 " -> out_error=1.
4. "4294967295 " -> 0xFFFFFFFF. "4294967296 " -> out_error=1. "12x4 5 " -> error result, then value 5. Lone "- " -> error.
5. Backpressure: "7 8 " with out_ready=0 for 5 cycles -> in_ready=0 while out_value=7 is held; after release, 8 is emitted; no characters lost.
6. Reset mid-token: "99", rst_n low one cycle, then "5 " -> single result 5. With ASCII_NUM_UNDERSCORE_EN: "1_000 " -> 1000. Without it: the same input -> out_error=1.
